// File: rtl/packet_downsizer_fifo_if.sv
// Bus bundle for packet_downsizer_fifo: wide packet input, narrow beat output, status.
interface packet_downsizer_fifo_if #(
  parameter int unsigned IN_W     = 256,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned LENGTH_W = 8,
  parameter int unsigned DEPTH    = 64
);
  localparam int unsigned BPW  = OUT_W / 8;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic [LENGTH_W-1:0] in_len;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic [BPW-1:0]      out_keep;
  logic                out_last;
  logic                len_err;
  logic [CNTW-1:0]     word_cnt;
  logic [CNTW-1:0]     pkt_cnt;

  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last, len_err, word_cnt, pkt_cnt
  );

  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last, len_err, word_cnt, pkt_cnt
  );
endinterface

// File: rtl/packet_downsizer_fifo.sv
// Packet FIFO: one wide word per packet in, OUT_W-bit beats with keep/last out.
// Per-word keep/last is stored with the data, so packet boundaries need no side FIFO.
module packet_downsizer_fifo #(
  parameter int unsigned IN_W     = 256,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned LENGTH_W = 8,
  parameter int unsigned DEPTH    = 64
) (
  input logic                    clk,
  input logic                    nrst,
  packet_downsizer_fifo_if.slave bus
);
  localparam int unsigned RATIO     = IN_W / OUT_W;
  localparam int unsigned BPW       = OUT_W / 8;
  localparam int unsigned ADDRW     = $clog2(DEPTH);
  localparam int unsigned PTRW      = ADDRW + 1;
  localparam int unsigned CNTW      = $clog2(DEPTH + 1);
  localparam int unsigned LW        = CNTW + LENGTH_W;
  localparam int unsigned MAX_BYTES = IN_W / 8;

  logic [OUT_W-1:0] r_mem_data [DEPTH];
  logic [BPW-1:0]   r_mem_keep [DEPTH];
  logic             r_mem_last [DEPTH];

  logic [PTRW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]  r_word_cnt, r_pkt_cnt;
  logic             r_in_ready, r_len_err;
  logic             r_out_valid, r_out_last;
  logic [OUT_W-1:0] r_out_data;
  logic [BPW-1:0]   r_out_keep;

  logic [LW-1:0]    w_len, w_nw, w_rem;
  logic [BPW-1:0]   w_last_keep;
  logic             w_legal, w_offer, w_accept, w_handoff, w_mem_empty, w_load;
  logic [CNTW-1:0]  w_word_cnt_nxt;

  // Length decode, handshake qualification and next occupancy
  always_comb begin
    w_len          = LW'(bus.in_len);
    w_legal        = (w_len != '0) && (w_len <= LW'(MAX_BYTES));
    w_nw           = (w_len + LW'(BPW - 1)) / LW'(BPW);
    w_rem          = w_len % LW'(BPW);
    w_last_keep    = (w_rem == '0) ? '1 : BPW'((LW'(1) << w_rem) - LW'(1));
    w_offer        = bus.in_valid & r_in_ready;
    w_accept       = w_offer & w_legal;
    w_handoff      = r_out_valid & bus.out_ready;
    w_mem_empty    = (r_wr_ptr == r_rd_ptr);
    w_load         = !w_mem_empty && (!r_out_valid || bus.out_ready);
    w_word_cnt_nxt = r_word_cnt + (w_accept ? CNTW'(w_nw) : '0) - CNTW'(w_handoff);
  end

  // Scatter the accepted packet into consecutive words; no reset on storage
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < int'(RATIO); i++) begin
        if (LW'(i) < w_nw) begin
          r_mem_data[r_wr_ptr[ADDRW-1:0] + ADDRW'(i)] <= bus.in_data[i*OUT_W +: OUT_W];
          r_mem_keep[r_wr_ptr[ADDRW-1:0] + ADDRW'(i)] <=
            (LW'(i) == w_nw - LW'(1)) ? w_last_keep : '1;
          r_mem_last[r_wr_ptr[ADDRW-1:0] + ADDRW'(i)] <= (LW'(i) == w_nw - LW'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_word_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_in_ready  <= 1'b1;
      r_len_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTRW'(w_nw);
      end
      // Show-ahead output register
      if (w_load) begin
        r_rd_ptr    <= r_rd_ptr + PTRW'(1);
        r_out_valid <= 1'b1;
        r_out_data  <= r_mem_data[r_rd_ptr[ADDRW-1:0]];
        r_out_keep  <= r_mem_keep[r_rd_ptr[ADDRW-1:0]];
        r_out_last  <= r_mem_last[r_rd_ptr[ADDRW-1:0]];
      end else if (w_handoff) begin
        r_out_valid <= 1'b0;
      end
      r_word_cnt <= w_word_cnt_nxt;
      r_pkt_cnt  <= r_pkt_cnt + CNTW'(w_accept) - CNTW'(w_handoff & r_out_last);
      r_len_err  <= w_offer & ~w_legal;
      r_in_ready <= (w_word_cnt_nxt <= CNTW'(DEPTH - RATIO));
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_keep  = r_out_keep;
  assign bus.out_last  = r_out_last;
  assign bus.len_err   = r_len_err;
  assign bus.word_cnt  = r_word_cnt;
  assign bus.pkt_cnt   = r_pkt_cnt;
endmodule

// File: tb/tb_packet_downsizer_fifo.sv
// Directed bench for packet_downsizer_fifo: table of single packets plus multi-cycle sequences.
module tb_packet_downsizer_fifo;
  localparam int unsigned IN_W     = 256;
  localparam int unsigned OUT_W    = 32;
  localparam int unsigned LENGTH_W = 8;
  localparam int unsigned DEPTH    = 64;

  typedef struct {
    logic [7:0] len;
    int         nw;
    logic [3:0] last_keep;
  } vec_t;

  logic clk = 1'b0;
  logic nrst;
  int   n_tests = 0;
  int   n_fail  = 0;

  packet_downsizer_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LENGTH_W(LENGTH_W), .DEPTH(DEPTH)) bus ();

  packet_downsizer_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .LENGTH_W(LENGTH_W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(int p, int i);
    return 32'(32'hC0DE_0000 + p * 256 + i);
  endfunction

  function automatic logic [255:0] mk_data(int p);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = word(p, i);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] len, input int p);
    for (int c = 0; c < 100 && !bus.in_ready; c++) tick();
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_len   = len;
    bus.in_data  = mk_data(p);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Accept beats first..upto-1 of packet p with out_ready held high
  task automatic collect(input int p, input int first, input int upto, input int nw,
                         input logic [3:0] last_keep);
    logic [3:0]  k;
    logic [31:0] m;
    bus.out_ready = 1'b1;
    for (int b = first; b < upto; b++) begin
      for (int c = 0; c < 20 && !bus.out_valid; c++) tick();
      check("beat_valid", 64'(bus.out_valid), 64'd1);
      k = (b == nw - 1) ? last_keep : 4'hF;
      for (int j = 0; j < 4; j++) m[j*8 +: 8] = {8{k[j]}};
      check("beat_data", 64'(bus.out_data & m), 64'(word(p, b) & m));
      check("beat_keep", 64'(bus.out_keep), 64'(k));
      check("beat_last", 64'(bus.out_last), 64'(b == nw - 1));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{len: 8'd32, nw: 8, last_keep: 4'hF};
    vecs[1] = '{len: 8'd5,  nw: 2, last_keep: 4'h1};
    vecs[2] = '{len: 8'd12, nw: 3, last_keep: 4'hF};
    vecs[3] = '{len: 8'd1,  nw: 1, last_keep: 4'h1};
    vecs[4] = '{len: 8'd31, nw: 8, last_keep: 4'h7};
    vecs[5] = '{len: 8'd4,  nw: 1, last_keep: 4'hF};
    vecs[6] = '{len: 8'd30, nw: 8, last_keep: 4'h3};

    nrst          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_len    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_keep",  64'(bus.out_keep),  64'd0);
    check("rst_out_last",  64'(bus.out_last),  64'd0);
    check("rst_len_err",   64'(bus.len_err),   64'd0);
    check("rst_word_cnt",  64'(bus.word_cnt),  64'd0);
    check("rst_pkt_cnt",   64'(bus.pkt_cnt),   64'd0);
    nrst = 1'b1;
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single packets, full drain each
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].len, v);
      check("vec_word_cnt_in", 64'(bus.word_cnt), 64'(vecs[v].nw));
      check("vec_pkt_cnt_in",  64'(bus.pkt_cnt),  64'd1);
      check("vec_valid_lat",   64'(bus.out_valid), 64'd0);
      collect(v, 0, vecs[v].nw, vecs[v].nw, vecs[v].last_keep);
      check("vec_drained_valid", 64'(bus.out_valid), 64'd0);
      check("vec_word_cnt_out",  64'(bus.word_cnt),  64'd0);
      check("vec_pkt_cnt_out",   64'(bus.pkt_cnt),   64'd0);
    end

    // Backpressure: beat 0 held stable while out_ready is low
    bus.out_ready = 1'b0;
    send(8'd12, 20);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_data",  64'(bus.out_data),  64'(word(20, 0)));
      check("bp_keep",  64'(bus.out_keep),  64'hF);
      check("bp_last",  64'(bus.out_last),  64'd0);
      tick();
    end
    collect(20, 0, 3, 3, 4'hF);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Fill to full with out_ready low
    bus.out_ready = 1'b0;
    for (int p = 0; p < 8; p++) begin
      send(8'd32, 30 + p);
      check("fill_word_cnt", 64'(bus.word_cnt), 64'(8 * (p + 1)));
    end
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_pkt_cnt",  64'(bus.pkt_cnt),  64'd8);
    for (int j = 0; j < 8; j++) begin
      check("pulse_data", 64'(bus.out_data), 64'(word(30, j)));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pulse_word_cnt", 64'(bus.word_cnt), 64'(63 - j));
      check("pulse_in_ready", 64'(bus.in_ready), 64'(j == 7));
    end
    // Simultaneous accept and handoff across the pointer wrap
    check("wrap_head", 64'(bus.out_data), 64'(word(31, 0)));
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_len    = 8'd32;
    bus.in_data   = mk_data(38);
    tick();
    bus.in_valid = 1'b0;
    check("wrap_word_cnt", 64'(bus.word_cnt), 64'd63);
    check("wrap_pkt_cnt",  64'(bus.pkt_cnt),  64'd8);
    collect(31, 1, 8, 8, 4'hF);
    for (int p = 32; p < 39; p++) collect(p, 0, 8, 8, 4'hF);
    check("wrap_drained",  64'(bus.out_valid), 64'd0);
    check("wrap_word_end", 64'(bus.word_cnt),  64'd0);
    check("wrap_pkt_end",  64'(bus.pkt_cnt),   64'd0);

    // Illegal lengths: zero and oversize
    send(8'd0, 50);
    check("err0_pulse",    64'(bus.len_err),  64'd1);
    check("err0_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("err0_pkt_cnt",  64'(bus.pkt_cnt),  64'd0);
    tick();
    check("err0_clear",    64'(bus.len_err),  64'd0);
    send(8'd40, 51);
    check("err40_pulse",    64'(bus.len_err),  64'd1);
    check("err40_word_cnt", 64'(bus.word_cnt), 64'd0);
    check("err40_pkt_cnt",  64'(bus.pkt_cnt),  64'd0);
    tick();
    check("err40_clear",    64'(bus.len_err),   64'd0);
    check("err_no_beats",   64'(bus.out_valid), 64'd0);

    // Reset mid-packet, then a fresh one-beat packet
    send(8'd32, 60);
    collect(60, 0, 3, 8, 4'hF);
    check("mid_beat3", 64'(bus.out_data), 64'(word(60, 3)));
    bus.out_ready = 1'b0;
    nrst = 1'b0;
    #1;
    check("mid_rst_valid",    64'(bus.out_valid), 64'd0);
    check("mid_rst_data",     64'(bus.out_data),  64'd0);
    check("mid_rst_keep",     64'(bus.out_keep),  64'd0);
    check("mid_rst_last",     64'(bus.out_last),  64'd0);
    check("mid_rst_word_cnt", 64'(bus.word_cnt),  64'd0);
    check("mid_rst_pkt_cnt",  64'(bus.pkt_cnt),   64'd0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    send(8'd4, 61);
    collect(61, 0, 1, 1, 4'hF);
    check("post_rst_drained", 64'(bus.out_valid), 64'd0);
    check("post_rst_word",    64'(bus.word_cnt),  64'd0);
    check("post_rst_pkt",     64'(bus.pkt_cnt),   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_downsizer_fifo.md
Name: packet_downsizer_fifo

Overview:
- Variable-length packet FIFO that takes one wide word per packet, up to IN_W bits with a byte length, and emits it as a stream of OUT_W-bit beats.
- Output beats carry a byte keep and a last flag; the output is a ready/valid handshake with full backpressure.
- Per-word keep/last metadata is stored alongside the data, so no separate length FIFO is needed.
- Sits between the task dispatcher's per-channel write side and narrow downstream consumers; PARALLELISM instances are used, one per channel.

Parameters:
- IN_W, 256: input data width in bits; multiple of OUT_W.
- OUT_W, 32: output beat width in bits; multiple of 8.
- LENGTH_W, 8: width of the byte-length field.
- DEPTH, 64: storage in OUT_W words; power of two, ≥ 2*RATIO.
- Derived: RATIO = IN_W/OUT_W; BPW = OUT_W/8; ADDRW = $clog2(DEPTH); CNTW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  input packet present.
- in_ready  out  1  block can accept one maximum-size packet.
- in_data  in  IN_W  packet payload; byte 0 at bits [7:0].
- in_len  in  LENGTH_W  packet length in bytes; legal range 1..IN_W/8.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  OUT_W  beat payload.
- out_keep  out  BPW  byte-valid mask, LSB = byte 0.
- out_last  out  1  final beat of a packet.
- len_err  out  1  one-cycle pulse: an illegal in_len was offered.
- word_cnt  out  CNTW  words held, memory plus output register.
- pkt_cnt  out  CNTW  packets whose last beat has not yet been handed off.

Behaviour:
- Reset (asynchronous, nrst low): clears pointers, counters and the output register. Out_valid=0, out_data=0, out_keep=0, out_last=0, len_err=0, word_cnt=0, pkt_cnt=0.
- Reset asserted mid-packet drops all stored data, including partially emitted packets. Deassertion is synchronous-safe and needs no flush cycle.
- Words per packet: nw = ceil(in_len*8/OUT_W), computed at CNTW+LENGTH_W width with no truncation.
- in_ready = (DEPTH - word_cnt ≥ RATIO); it is a registered-state function only and does not depend on in_valid.
- Accept = in_valid & in_ready & legal length.
  - On accept, words 0..nw-1 are written at wr_ptr+i (mod DEPTH).
  - keep = all ones for every word except the last. The last word's keep = low (in_len mod BPW) bits set, or all ones if the remainder is 0.
  - last = 1 only on word nw-1. wr_ptr advances by nw.
- Illegal length (in_len==0 or in_len>IN_W/8) with in_valid & in_ready: nothing is written, pointers are unchanged, and len_err pulses high for the next cycle.
- Pointers are ADDRW+1 bits with a wrap bit. Memory empty = pointers equal.
- Output register (show-ahead):
  - It loads mem[rd_ptr] whenever memory is non-empty and (out_valid==0 or out_ready==1).
  - On load, rd_ptr increments, wrapping naturally at DEPTH.
- Latency: a packet accepted at edge k, into an empty block, gives out_valid=1 after edge k+1 with beat 0.
- Consecutive beats stream at one per cycle while out_ready=1.
- While out_valid & ~out_ready, out_data, out_keep and out_last hold stable.
- out_valid falls after the handoff edge only if memory is empty.
- word_cnt next = word_cnt + (accept ? nw : 0) − (out_valid & out_ready ? 1 : 0). Simultaneous accept and handoff apply both in the same cycle.
- pkt_cnt next = pkt_cnt + accept − (out_valid & out_ready & out_last). Both changes in one cycle net out.
- Full boundary: when word_cnt > DEPTH−RATIO, in_ready=0. It regains 1 in the cycle after enough handoffs.
- Empty boundary: no beats are emitted and out_ready is ignored.
- in_data bits beyond in_len are don't-care. Unwritten lanes of a partial last word are not cleared; keep defines validity.

Test Plan:
1. in_len=32, words 0x00..0x07 → 8 beats 0..7, keep=0xF each, out_last only on beat 8, pkt_cnt 1→0 after beat 8.
2. in_len=5 → 2 beats, keep 0xF then 0x1, out_last on beat 2, word_cnt 2→0.
3. Backpressure: in_len=12 with out_ready low for cycles 2–4 → out_data/keep/last constant, then 3 beats in order, no loss or duplicate.
4. Fill with out_ready=0: 8 packets of 32 bytes.
   - Expect word_cnt=64 and in_ready=0 after the 8th.
   - Single out_ready pulses bring it to 63..57 with in_ready still 0.
   - At word_cnt=56, in_ready=1.
   - Then write plus read in the same cycle at the wrap: data continuity is correct.
5. in_len=0, then in_len=40 (>32) → len_err pulses once per offer, word_cnt and pkt_cnt unchanged, no beats.
6. Assert nrst during beat 3 of a 32-byte packet → outputs 0 immediately. After release, a new in_len=4 packet yields exactly 1 beat with keep=0xF and last=1.
